// File: rtl/maj_fold_pkg.sv
// rtl/maj_fold_pkg.sv - shared types, sizing helpers and default constants for the folded majority evaluator
package maj_fold_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic logic [63:0] low_mask(input int bits);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++)
      if (i < bits) m[i] = 1'b1;
    return m;
  endfunction

  localparam int N_DEF  = 65;
  localparam int W_DEF  = 8;
  localparam int CW     = clog2(N_DEF + 1);
  localparam int NCHUNK = ceil_div(N_DEF, W_DEF);
  localparam logic [W_DEF-1:0] LAST_MASK = W_DEF'(low_mask(N_DEF - (NCHUNK - 1) * W_DEF));

endpackage

// File: rtl/maj_fold_popcnt.sv
// rtl/maj_fold_popcnt.sv - combinational masked popcount of one W-bit chunk
module maj_fold_popcnt
  import maj_fold_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]             data,
  input  logic [W-1:0]             mask,
  output logic [clog2(W+1)-1:0]    count
);

  localparam int PW = clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++)
      count = count + PW'(data[i] & mask[i]);
  end

endmodule

// File: rtl/maj_fold_seq.sv
// rtl/maj_fold_seq.sv - folded sequential majority evaluator, one W-bit chunk per cycle
// Optional early termination once the result is decided: MAJ_FOLD_EARLY_EXIT_EN
module maj_fold_seq
  import maj_fold_pkg::*;
#(
  parameter int N   = 65,
  parameter int W   = 8,
  parameter int THR = N / 2 + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_maj,
  output logic [clog2(N+1)-1:0]    out_count,
  output logic                     busy
);

  localparam int CW_L = clog2(N + 1);
  localparam int NCH  = ceil_div(N, W);
  localparam int NP   = NCH * W;
  localparam int PW   = clog2(W + 1);
  localparam int IW   = clog2(NCH + 1);
  localparam logic [CW_L:0] THR_C = (CW_L + 1)'(THR);

  function automatic logic [W-1:0] tail_mask();
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++)
      if (i < N - (NCH - 1) * W) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [W-1:0] TAIL_MASK = tail_mask();

  state_e            state_q, state_d;
  logic [NP-1:0]     sh_q;
  logic [CW_L-1:0]   cnt_q, cnt_nx, count_q;
  logic [IW-1:0]     idx_q;
  logic              maj_q;
  logic              load, finish, last, stop_now;
  logic [W-1:0]      mask;
  logic [PW-1:0]     pc;

  // The vector shifts down one chunk per cycle, so the active chunk is always the low W bits.
  assign last = (idx_q == IW'(NCH - 1));
  assign mask = last ? TAIL_MASK : '1;

  maj_fold_popcnt #(.W(W)) u_popcnt (
    .data  (sh_q[W-1:0]),
    .mask  (mask),
    .count (pc)
  );

  assign cnt_nx = cnt_q + CW_L'(pc);

`ifdef MAJ_FOLD_EARLY_EXIT_EN
  logic [CW_L:0] rem;

  always_comb begin
    int done_bits;
    done_bits = (int'(idx_q) + 1) * W;
    if (done_bits > N) done_bits = N;
    rem = (CW_L + 1)'(N - done_bits);
  end

  // Stop once the remaining bits can no longer move the count across the threshold.
  assign stop_now = last || ({1'b0, cnt_nx} >= THR_C) || (({1'b0, cnt_nx} + rem) < THR_C);
`else
  assign stop_now = last;
`endif

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    finish   = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (stop_now) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      maj_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sh_q  <= NP'(in_vec);
        cnt_q <= '0;
        idx_q <= '0;
      end else if (state_q == ACCUM) begin
        sh_q  <= sh_q >> W;
        cnt_q <= cnt_nx;
        idx_q <= idx_q + 1'b1;
      end
      if (finish) begin
        maj_q   <= ({1'b0, cnt_nx} >= THR_C);
        count_q <= cnt_nx;
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_maj   = maj_q;
  assign out_count = count_q;
  assign busy      = (state_q != IDLE);

endmodule
